// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    INC   = 2'd2,
    CARRY = 2'd3
  } state_t;

  localparam logic [7:0]  SEC_LIMIT_DEF = 8'h60;
  localparam logic [15:0] MIN_STEP_DEF  = 16'h0100;

  // BCD field slices of the {M1,M0,S1,S0} count word
  localparam int SEC_LO_MSB = 7;
  localparam int SEC_LO_LSB = 0;
  localparam int MIN_HI_MSB = 15;
  localparam int MIN_HI_LSB = 8;

endpackage

// File: rtl/stopwatch_seq_ctrl.sv
// Sequencing controller for the stopwatch BCD adder: runs a seconds pass per
// tick and a minute-carry pass when seconds reach the limit; owns run/stop,
// clear, lap freeze and the sticky wrap flag.
module stopwatch_seq_ctrl
  import stopwatch_pkg::*;
#(
  parameter logic [7:0]  SEC_LIMIT = SEC_LIMIT_DEF,
  parameter logic [15:0] MIN_STEP  = MIN_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  output logic [15:0] count,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        busy,
  output logic        ovf
);

  state_t      state, state_n;
  logic [15:0] snap, snap_n, count_n;
  logic        run_n, lap_n, ovf_n, pend, pend_n;

  // Adder operand drive and busy flag decoded from the current state
  always_comb begin
    add_a   = count;
    add_b   = '0;
    add_cin = 1'b0;
    busy    = 1'b0;
    case (state)
      INC: begin
        add_cin = 1'b1;
        busy    = 1'b1;
      end
      CARRY: begin
        add_b = MIN_STEP;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, count, flag and snapshot computation
  always_comb begin
    state_n = state;
    count_n = count;
    snap_n  = snap;
    lap_n   = lap_active;
    ovf_n   = ovf;
    pend_n  = pend;
    run_n   = running ^ start_stop;

    if (clear) begin
      // clear aborts any pass; start_stop still toggles running alongside it
      count_n = '0;
      snap_n  = '0;
      lap_n   = 1'b0;
      ovf_n   = 1'b0;
      pend_n  = 1'b0;
      state_n = run_n ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_stop) state_n = RUN;
        end
        RUN: begin
          if (start_stop) begin
            state_n = IDLE;
          end else if (tick || pend) begin
            state_n = INC;
            pend_n  = 1'b0;
          end
        end
        INC: begin
          if (tick) pend_n = 1'b1;
          if (add_sum[SEC_LO_MSB:SEC_LO_LSB] == SEC_LIMIT) begin
            count_n = {count[MIN_HI_MSB:MIN_HI_LSB], 8'h00};
            state_n = CARRY;
          end else begin
            count_n = add_sum;
            state_n = run_n ? RUN : IDLE;
          end
        end
        CARRY: begin
          if (tick) pend_n = 1'b1;
          if (add_cout) begin
            count_n = '0;
            ovf_n   = 1'b1;
          end else begin
            count_n = add_sum;
          end
          state_n = run_n ? RUN : IDLE;
        end
        default: state_n = IDLE;
      endcase

      // Stopping drops any queued tick but keeps one arriving in the same cycle
      if (running && start_stop) pend_n = tick;

      if (!start_stop && lap) begin
        if (lap_active) begin
          lap_n = 1'b0;
        end else if (running) begin
          snap_n = count;
          lap_n  = 1'b1;
        end
      end
    end
  end

  // State and datapath registers; disp is registered from the next values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      snap       <= '0;
      disp       <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      ovf        <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      snap       <= snap_n;
      disp       <= lap_n ? snap_n : count_n;
      running    <= run_n;
      lap_active <= lap_n;
      ovf        <= ovf_n;
      pend       <= pend_n;
    end
  end

endmodule

// File: tb/tb_stopwatch_seq_ctrl.sv
// Self-checking bench for stopwatch_seq_ctrl with a behavioural BCD adder.
module tb_stopwatch_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] add_a, add_b, add_sum, count, disp;
  logic        add_cin, add_cout, running, lap_active, busy, ovf;

  int checks = 0;
  int failures = 0;

  stopwatch_seq_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .count(count), .disp(disp), .running(running),
    .lap_active(lap_active), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    logic [15:0] s;
    logic        cy;
    int          d;
    s  = '0;
    cy = c;
    for (int i = 0; i < 4; i++) begin
      d = int'(a[i*4 +: 4]) + int'(b[i*4 +: 4]) + int'(cy);
      if (d > 9) begin
        d  = d - 10;
        cy = 1'b1;
      end else begin
        cy = 1'b0;
      end
      s[i*4 +: 4] = 4'(d);
    end
    return {cy, s};
  endfunction

  always_comb {add_cout, add_sum} = bcd_add(add_a, add_b, add_cin);

  // Total elapsed seconds to {M1,M0,S1,S0}
  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = (secs / 60) % 100;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  typedef struct packed {
    logic        tk, ss, clr, lp;
    logic [15:0] cnt, dsp;
    logic        run, lapa, bsy, ov;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic tk, input logic ss, input logic clr, input logic lp,
                              input logic [15:0] cnt, input logic [15:0] dsp,
                              input logic run, input logic lapa, input logic bsy,
                              input logic ov);
    vec_t v;
    v = {tk, ss, clr, lp, cnt, dsp, run, lapa, bsy, ov};
    return v;
  endfunction

  function automatic logic [35:0] status();
    return {count, disp, running, lap_active, busy, ovf};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic tk, input logic ss, input logic clr, input logic lp);
    tick = tk; start_stop = ss; clear = clr; lap = lp;
    step();
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  // One tick followed by enough idle cycles for a full INC+CARRY sequence
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      step();
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 16'h0001, 16'h0001, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 16'h0001, 16'h0001, 1, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 16'h0002, 16'h0002, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 16'h0002, 16'h0002, 1, 1, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 16'h0002, 16'h0002, 1, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 16'h0003, 16'h0002, 1, 1, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 16'h0003, 16'h0002, 1, 1, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 16'h0004, 16'h0002, 1, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 16'h0004, 16'h0002, 1, 1, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 16'h0005, 16'h0002, 1, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 16'h0005, 16'h0005, 1, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 16'h0005, 16'h0005, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 16'h0005, 16'h0005, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

    // Reset state
    step();
    step();
    check("reset_status", 64'(status()), 64'd0);
    check("reset_adder", 64'({add_a, add_b, add_cin}), 64'd0);
    rst = 1'b0;
    step();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 18; i++) begin
      pulse(tbl[i].tk, tbl[i].ss, tbl[i].clr, tbl[i].lp);
      check($sformatf("vec%0d", i), 64'(status()),
            64'({tbl[i].cnt, tbl[i].dsp, tbl[i].run, tbl[i].lapa, tbl[i].bsy, tbl[i].ov}));
    end

    // Seconds increment latency at 00:09
    pulse(0, 1, 0, 0);
    run_ticks(9);
    check("cnt_0009", 64'(count), 64'(to_bcd(9)));
    pulse(1, 0, 0, 0);
    check("inc_edge1", 64'({count, busy}), 64'({16'h0009, 1'b1}));
    step();
    check("inc_edge2", 64'({count, busy}), 64'({16'h0010, 1'b0}));

    // Minute carry at 12:59
    run_ticks(769);
    check("cnt_1259", 64'(count), 64'(16'h1259));
    pulse(1, 0, 0, 0);
    check("carry_edge1", 64'({count, busy}), 64'({16'h1259, 1'b1}));
    step();
    check("carry_edge2", 64'({count, busy, add_b}), 64'({16'h1200, 1'b1, 16'h0100}));
    step();
    check("carry_edge3", 64'({count, busy}), 64'({16'h1300, 1'b0}));

    // Wrap from 99:59
    run_ticks(5219);
    check("cnt_9959", 64'({count, ovf}), 64'({16'h9959, 1'b0}));
    run_ticks(1);
    check("wrap", 64'({count, ovf}), 64'({16'h0000, 1'b1}));
    run_ticks(1);
    check("wrap_sticky", 64'({count, ovf}), 64'({16'h0001, 1'b1}));
    pulse(0, 0, 1, 0);
    check("clear_ovf", 64'({count, ovf, running}), 64'({16'h0000, 1'b0, 1'b1}));

    // Lap freeze at 03:20
    run_ticks(200);
    pulse(0, 0, 0, 1);
    check("lap_on", 64'({disp, lap_active}), 64'({16'h0320, 1'b1}));
    run_ticks(5);
    check("lap_frozen", 64'({count, disp}), 64'({16'h0325, 16'h0320}));
    pulse(0, 0, 0, 1);
    check("lap_off", 64'({disp, lap_active}), 64'({16'h0325, 1'b0}));
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    check("lap_stopped", 64'({disp, lap_active, running}), 64'({16'h0325, 1'b0, 1'b0}));

    // Ticks during INC and CARRY: only one extra increment
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);
    run_ticks(59);
    check("cnt_0059", 64'(count), 64'(16'h0059));
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    check("pend_carry", 64'({count, busy}), 64'({16'h0000, 1'b1}));
    pulse(1, 0, 0, 0);
    check("pend_run", 64'({count, busy}), 64'({16'h0100, 1'b0}));
    step();
    check("pend_inc", 64'(busy), 64'(1'b1));
    step();
    step();
    step();
    step();
    check("pend_once", 64'({count, busy}), 64'({16'h0101, 1'b0}));

    // clear and start_stop together
    pulse(0, 1, 1, 0);
    check("clr_ss", 64'({count, running, busy}), 64'({16'h0000, 1'b0, 1'b0}));

    // Asynchronous reset during CARRY at 05:59
    pulse(0, 1, 0, 0);
    run_ticks(359);
    check("cnt_0559", 64'(count), 64'(16'h0559));
    pulse(1, 0, 0, 0);
    step();
    check("in_carry", 64'({count, busy}), 64'({16'h0500, 1'b1}));
    #2 rst = 1'b1;
    #1;
    check("async_rst", 64'(status()), 64'd0);
    check("async_rst_adder", 64'({add_a, add_b, add_cin}), 64'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", 64'({running, busy, count}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
